// File: rtl/xor_memory_rmw_frontend.sv
// rtl/xor_memory_rmw_frontend.sv - read-modify-write front end for the multi-port XOR memory
//
// Turns per-port "add delta to the counter at addr" requests into a read cycle
// followed by a write cycle on the matching memory port. The result is a
// saturating counter bank. After reset the whole memory is cleared through
// port 0. Updates are accepted only after that sweep has finished.
//
// Ports (all per-port signals are unpacked arrays of PORTS entries):
//   clk, rst_n           clock, asynchronous active-low reset
//   upd_valid/addr/delta update request; accepted when upd_valid && upd_ready
//   upd_ready            port can accept a request this cycle
//   done_valid/value     1-cycle pulse with the value written (post-saturation)
//   init_done            high once the clear sweep has finished
//   mem_addr/d/en        to memory; mem_en=1 is a write, mem_en=0 a read
//   mem_q                from memory; data for the address of cycle t appears in t+1
module xor_memory_rmw_frontend #(
   parameter int  WIDTH   = 8,
   parameter int  DEPTH   = 256,
   parameter int  PORTS   = 2,
   parameter int  DELTA_W = 4,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               upd_valid  [PORTS],
   input  logic [AW-1:0]      upd_addr   [PORTS],
   input  logic [DELTA_W-1:0] upd_delta  [PORTS],
   output logic               upd_ready  [PORTS],
   output logic               done_valid [PORTS],
   output logic [WIDTH-1:0]   done_value [PORTS],
   output logic               init_done,
   output logic [AW-1:0]      mem_addr   [PORTS],
   output logic [WIDTH-1:0]   mem_d      [PORTS],
   output logic               mem_en     [PORTS],
   input  logic [WIDTH-1:0]   mem_q      [PORTS]
);

   typedef enum logic {G_INIT, G_RUN} g_state_e;
   typedef enum logic {P_IDLE, P_WR}  p_state_e;

   g_state_e           g_q, g_d;
   logic [AW-1:0]      sweep_q, sweep_d;

   // Per-port pipeline state captured at accept
   p_state_e           st_q       [PORTS];
   p_state_e           st_d       [PORTS];
   logic [AW-1:0]      addr_q     [PORTS];
   logic [AW-1:0]      addr_d     [PORTS];
   logic [DELTA_W-1:0] delta_q    [PORTS];
   logic [DELTA_W-1:0] delta_d    [PORTS];
   logic               fwd_hit_q  [PORTS];
   logic               fwd_hit_d  [PORTS];
   logic [WIDTH-1:0]   fwd_data_q [PORTS];
   logic [WIDTH-1:0]   fwd_data_d [PORTS];

   // Copy of every port's write from the previous cycle; the memory has not
   // committed it yet when a read is issued this cycle.
   logic               pw_valid_q [PORTS];
   logic [AW-1:0]      pw_addr_q  [PORTS];
   logic [WIDTH-1:0]   pw_data_q  [PORTS];

   logic               block      [PORTS];
   logic               fwd_hit_c  [PORTS];
   logic [WIDTH-1:0]   fwd_data_c [PORTS];
   logic [WIDTH-1:0]   base_c     [PORTS];
   logic [WIDTH:0]     ext_c      [PORTS];
   logic [WIDTH-1:0]   sum_c      [PORTS];

   // Hazard detection, forwarding lookup and saturating add
   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         block[p]      = 1'b0;
         fwd_hit_c[p]  = 1'b0;
         fwd_data_c[p] = '0;
         for (int q = 0; q < PORTS; q++) begin
            // Lower index wins a same-cycle address collision
            if (q < p && upd_valid[q] && upd_addr[q] == upd_addr[p]) begin
               block[p] = 1'b1;
            end
            // Never read an address that is being written this cycle
            if (st_q[q] == P_WR && addr_q[q] == upd_addr[p]) begin
               block[p] = 1'b1;
            end
            // Writes never collide, so at most one entry can match
            if (pw_valid_q[q] && pw_addr_q[q] == upd_addr[p]) begin
               fwd_hit_c[p]  = 1'b1;
               fwd_data_c[p] = pw_data_q[q];
            end
         end
         base_c[p] = fwd_hit_q[p] ? fwd_data_q[p] : mem_q[p];
         ext_c[p]  = {1'b0, base_c[p]} + (WIDTH+1)'(delta_q[p]);
         sum_c[p]  = ext_c[p][WIDTH] ? {WIDTH{1'b1}} : ext_c[p][WIDTH-1:0];
      end
   end

   // Next state and outputs
   always_comb begin
      g_d       = g_q;
      sweep_d   = sweep_q;
      init_done = (g_q == G_RUN);
      for (int p = 0; p < PORTS; p++) begin
         st_d[p]       = st_q[p];
         addr_d[p]     = addr_q[p];
         delta_d[p]    = delta_q[p];
         fwd_hit_d[p]  = fwd_hit_q[p];
         fwd_data_d[p] = fwd_data_q[p];
         upd_ready[p]  = 1'b0;
         done_valid[p] = 1'b0;
         done_value[p] = '0;
         mem_addr[p]   = '0;
         mem_d[p]      = '0;
         mem_en[p]     = 1'b0;
      end

      if (g_q == G_INIT) begin
         mem_en[0]   = 1'b1;
         mem_addr[0] = sweep_q;
         sweep_d     = sweep_q + AW'(1);
         if (sweep_q == AW'(DEPTH - 1)) begin
            g_d = G_RUN;
         end
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            if (st_q[p] == P_IDLE) begin
               upd_ready[p] = ~block[p];
               mem_addr[p]  = upd_addr[p];
               if (upd_valid[p] && !block[p]) begin
                  st_d[p]       = P_WR;
                  addr_d[p]     = upd_addr[p];
                  delta_d[p]    = upd_delta[p];
                  fwd_hit_d[p]  = fwd_hit_c[p];
                  fwd_data_d[p] = fwd_data_c[p];
               end
            end else begin
               mem_addr[p]   = addr_q[p];
               mem_d[p]      = sum_c[p];
               mem_en[p]     = 1'b1;
               done_valid[p] = 1'b1;
               done_value[p] = sum_c[p];
               st_d[p]       = P_IDLE;
            end
         end
      end

      // The reset state is INIT, which drives a write; silence the memory
      // while reset is held rather than waiting for a clock edge.
      if (!rst_n) begin
         init_done = 1'b0;
         for (int p = 0; p < PORTS; p++) begin
            upd_ready[p]  = 1'b0;
            done_valid[p] = 1'b0;
            done_value[p] = '0;
            mem_addr[p]   = '0;
            mem_d[p]      = '0;
            mem_en[p]     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q     <= G_INIT;
         sweep_q <= '0;
         for (int p = 0; p < PORTS; p++) begin
            st_q[p]       <= P_IDLE;
            addr_q[p]     <= '0;
            delta_q[p]    <= '0;
            fwd_hit_q[p]  <= 1'b0;
            fwd_data_q[p] <= '0;
            pw_valid_q[p] <= 1'b0;
            pw_addr_q[p]  <= '0;
            pw_data_q[p]  <= '0;
         end
      end else begin
         g_q     <= g_d;
         sweep_q <= sweep_d;
         for (int p = 0; p < PORTS; p++) begin
            st_q[p]       <= st_d[p];
            addr_q[p]     <= addr_d[p];
            delta_q[p]    <= delta_d[p];
            fwd_hit_q[p]  <= fwd_hit_d[p];
            fwd_data_q[p] <= fwd_data_d[p];
            // Sweep writes are captured too: a read in the first RUN cycle
            // may target the last cleared address.
            pw_valid_q[p] <= mem_en[p];
            pw_addr_q[p]  <= mem_addr[p];
            pw_data_q[p]  <= mem_d[p];
         end
      end
   end

endmodule

// File: tb/tb_xor_memory_rmw_frontend.sv
// tb/tb_xor_memory_rmw_frontend.sv - directed self-checking bench for xor_memory_rmw_frontend
module tb_xor_memory_rmw_frontend;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 256;
   localparam int PORTS   = 2;
   localparam int DELTA_W = 4;
   localparam int AW      = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               upd_valid  [PORTS];
   logic [AW-1:0]      upd_addr   [PORTS];
   logic [DELTA_W-1:0] upd_delta  [PORTS];
   logic               upd_ready  [PORTS];
   logic               done_valid [PORTS];
   logic [WIDTH-1:0]   done_value [PORTS];
   logic               init_done;
   logic [AW-1:0]      mem_addr   [PORTS];
   logic [WIDTH-1:0]   mem_d      [PORTS];
   logic               mem_en     [PORTS];
   logic [WIDTH-1:0]   mem_q      [PORTS];

   // Memory model: registered read, writes commit one edge after they are issued
   logic [WIDTH-1:0]   mem    [DEPTH];
   logic               pend_v [PORTS];
   logic [AW-1:0]      pend_a [PORTS];
   logic [WIDTH-1:0]   pend_d [PORTS];
   logic               scramble = 1'b1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xor_memory_rmw_frontend #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .DELTA_W(DELTA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_delta(upd_delta),
      .upd_ready(upd_ready), .done_valid(done_valid), .done_value(done_value),
      .init_done(init_done), .mem_addr(mem_addr), .mem_d(mem_d),
      .mem_en(mem_en), .mem_q(mem_q)
   );

   always @(posedge clk) begin
      for (int p = 0; p < PORTS; p++) begin
         mem_q[p]  <= mem[mem_addr[p]];
         pend_v[p] <= mem_en[p];
         pend_a[p] <= mem_addr[p];
         pend_d[p] <= mem_d[p];
      end
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(8'hA5 ^ i);
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            if (pend_v[p]) mem[pend_a[p]] <= pend_d[p];
         end
      end
   end

   task automatic idle(input int n);
      for (int p = 0; p < PORTS; p++) upd_valid[p] = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      scramble = 1'b1;
      for (int p = 0; p < PORTS; p++) begin
         upd_valid[p] = 1'b0;
         upd_addr[p]  = '0;
         upd_delta[p] = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (init_done !== 1'b0) begin
         errors++; $display("FAIL reset_init_done: got %0b expected 0", init_done);
      end
      checks++;
      if (mem_en[0] !== 1'b0 || mem_en[1] !== 1'b0) begin
         errors++; $display("FAIL reset_mem_en: got %0b/%0b expected 0/0", mem_en[0], mem_en[1]);
      end
      checks++;
      if (upd_ready[0] !== 1'b0 || upd_ready[1] !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %0b/%0b expected 0/0", upd_ready[0], upd_ready[1]);
      end
      checks++;
      if (done_valid[0] !== 1'b0 || mem_addr[0] !== 8'd0 || mem_d[0] !== 8'd0 || done_value[0] !== 8'd0) begin
         errors++; $display("FAIL reset_outputs: got dv=%0b addr=%0d d=%0d val=%0d expected all 0",
                            done_valid[0], mem_addr[0], mem_d[0], done_value[0]);
      end
   endtask

   task automatic test_init_sweep();
      int nz;
      @(negedge clk);
      rst_n = 1'b1;
      scramble = 1'b0;
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (mem_en[0] !== 1'b1 || mem_addr[0] !== AW'(i) || mem_d[0] !== 8'd0 || mem_en[1] !== 1'b0 ||
             upd_ready[0] !== 1'b0 || upd_ready[1] !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_cycle_%0d: got en0=%0b addr=%0d d=%0d en1=%0b rdy=%0b%0b idone=%0b expected 1,%0d,0,0,00,0",
                     i, mem_en[0], mem_addr[0], mem_d[0], mem_en[1], upd_ready[0], upd_ready[1], init_done, i);
         end
         @(negedge clk);
         #1;
      end
      checks++;
      if (init_done !== 1'b1) begin
         errors++; $display("FAIL sweep_init_done: got %0b expected 1", init_done);
      end
      checks++;
      if (mem_en[0] !== 1'b0) begin
         errors++; $display("FAIL sweep_stops: got mem_en0=%0b expected 0", mem_en[0]);
      end
      idle(2);
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'd0) nz++;
      checks++;
      if (nz != 0) begin
         errors++; $display("FAIL sweep_cleared: got %0d nonzero entries expected 0", nz);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      upd_valid[0] = 1'b1; upd_addr[0] = 8'd5; upd_delta[0] = 4'd3;
      #1;
      checks++;
      if (upd_ready[0] !== 1'b1 || mem_en[0] !== 1'b0 || mem_addr[0] !== 8'd5) begin
         errors++; $display("FAIL single_read: got rdy=%0b en=%0b addr=%0d expected 1,0,5",
                            upd_ready[0], mem_en[0], mem_addr[0]);
      end
      @(negedge clk);
      upd_valid[0] = 1'b0;
      #1;
      checks++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== 8'd5 || mem_d[0] !== 8'd3 || upd_ready[0] !== 1'b0) begin
         errors++; $display("FAIL single_write: got en=%0b addr=%0d d=%0d rdy=%0b expected 1,5,3,0",
                            mem_en[0], mem_addr[0], mem_d[0], upd_ready[0]);
      end
      checks++;
      if (done_valid[0] !== 1'b1 || done_value[0] !== 8'd3) begin
         errors++; $display("FAIL single_done: got dv=%0b val=%0d expected 1,3", done_valid[0], done_value[0]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done_valid[0] !== 1'b0) begin
         errors++; $display("FAIL single_pulse: got dv=%0b expected 0", done_valid[0]);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         upd_valid[0] = 1'b1; upd_addr[0] = 8'd7; upd_delta[0] = 4'd1;
         #1;
         checks++;
         if (upd_ready[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_%0d: got %0b expected 1", k, upd_ready[0]);
         end
         @(negedge clk);
         upd_valid[0] = 1'b0;
         #1;
         checks++;
         if (done_valid[0] !== 1'b1 || done_value[0] !== WIDTH'(k)) begin
            errors++; $display("FAIL b2b_value_%0d: got dv=%0b val=%0d expected 1,%0d", k, done_valid[0], done_value[0], k);
         end
      end
      idle(3);
      checks++;
      if (mem[7] !== 8'd5) begin
         errors++; $display("FAIL b2b_mem: got %0d expected 5", mem[7]);
      end
   endtask

   task automatic test_parallel();
      @(negedge clk);
      upd_valid[0] = 1'b1; upd_addr[0] = 8'd40; upd_delta[0] = 4'd2;
      upd_valid[1] = 1'b1; upd_addr[1] = 8'd41; upd_delta[1] = 4'd3;
      #1;
      checks++;
      if (upd_ready[0] !== 1'b1 || upd_ready[1] !== 1'b1) begin
         errors++; $display("FAIL par_ready: got %0b/%0b expected 1/1", upd_ready[0], upd_ready[1]);
      end
      @(negedge clk);
      upd_valid[0] = 1'b0; upd_valid[1] = 1'b0;
      #1;
      checks++;
      if (done_value[0] !== 8'd2 || done_value[1] !== 8'd3 || mem_addr[0] !== 8'd40 || mem_addr[1] !== 8'd41 ||
          mem_en[0] !== 1'b1 || mem_en[1] !== 1'b1) begin
         errors++; $display("FAIL par_write: got val=%0d/%0d addr=%0d/%0d en=%0b/%0b expected 2/3 40/41 1/1",
                            done_value[0], done_value[1], mem_addr[0], mem_addr[1], mem_en[0], mem_en[1]);
      end
      idle(2);
   endtask

   task automatic test_conflict();
      @(negedge clk);
      upd_valid[0] = 1'b1; upd_addr[0] = 8'd9; upd_delta[0] = 4'd2;
      upd_valid[1] = 1'b1; upd_addr[1] = 8'd9; upd_delta[1] = 4'd4;
      #1;
      checks++;
      if (upd_ready[0] !== 1'b1 || upd_ready[1] !== 1'b0) begin
         errors++; $display("FAIL conf_priority: got %0b/%0b expected 1/0", upd_ready[0], upd_ready[1]);
      end
      @(negedge clk);
      upd_valid[0] = 1'b0;
      #1;
      checks++;
      if (upd_ready[1] !== 1'b0 || done_value[0] !== 8'd2) begin
         errors++; $display("FAIL conf_wr_block: got rdy1=%0b val0=%0d expected 0,2", upd_ready[1], done_value[0]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (upd_ready[1] !== 1'b1) begin
         errors++; $display("FAIL conf_release: got rdy1=%0b expected 1", upd_ready[1]);
      end
      @(negedge clk);
      upd_valid[1] = 1'b0;
      #1;
      checks++;
      if (done_valid[1] !== 1'b1 || done_value[1] !== 8'd6) begin
         errors++; $display("FAIL conf_sum: got dv=%0b val=%0d expected 1,6", done_valid[1], done_value[1]);
      end
      idle(3);
      checks++;
      if (mem[9] !== 8'd6) begin
         errors++; $display("FAIL conf_mem: got %0d expected 6", mem[9]);
      end
   endtask

   task automatic test_cross_forward();
      @(negedge clk);
      upd_valid[0] = 1'b1; upd_addr[0] = 8'd9; upd_delta[0] = 4'd1;
      @(negedge clk);
      upd_valid[0] = 1'b0;
      #1;
      checks++;
      if (done_value[0] !== 8'd7) begin
         errors++; $display("FAIL xfwd_p0: got %0d expected 7", done_value[0]);
      end
      @(negedge clk);
      upd_valid[1] = 1'b1; upd_addr[1] = 8'd9; upd_delta[1] = 4'd3;
      #1;
      checks++;
      if (upd_ready[1] !== 1'b1) begin
         errors++; $display("FAIL xfwd_ready: got %0b expected 1", upd_ready[1]);
      end
      @(negedge clk);
      upd_valid[1] = 1'b0;
      #1;
      checks++;
      if (done_valid[1] !== 1'b1 || done_value[1] !== 8'd10) begin
         errors++; $display("FAIL xfwd_p1: got dv=%0b val=%0d expected 1,10", done_valid[1], done_value[1]);
      end
      idle(3);
      checks++;
      if (mem[9] !== 8'd10) begin
         errors++; $display("FAIL xfwd_mem: got %0d expected 10", mem[9]);
      end
   endtask

   task automatic test_saturation();
      int dl [19];
      int ex [19];
      for (int k = 0; k < 16; k++) begin
         dl[k] = 15;
         ex[k] = 15 * (k + 1);
      end
      dl[16] = 10; ex[16] = 250;
      dl[17] = 15; ex[17] = 255;
      dl[18] = 1;  ex[18] = 255;
      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         upd_valid[0] = 1'b1; upd_addr[0] = 8'd30; upd_delta[0] = DELTA_W'(dl[k]);
         @(negedge clk);
         upd_valid[0] = 1'b0;
         #1;
         checks++;
         if (done_valid[0] !== 1'b1 || done_value[0] !== WIDTH'(ex[k])) begin
            errors++; $display("FAIL sat_step_%0d: got dv=%0b val=%0d expected 1,%0d", k, done_valid[0], done_value[0], ex[k]);
         end
      end
      idle(3);
      checks++;
      if (mem[30] !== 8'd255) begin
         errors++; $display("FAIL sat_mem: got %0d expected 255", mem[30]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      @(negedge clk);
      upd_valid[0] = 1'b1; upd_addr[0] = 8'd9; upd_delta[0] = 4'd4;
      @(negedge clk);
      upd_valid[0] = 1'b0;
      #1;
      checks++;
      if (mem_en[0] !== 1'b1 || mem_d[0] !== 8'd14) begin
         errors++; $display("FAIL rstmid_wr: got en=%0b d=%0d expected 1,14", mem_en[0], mem_d[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_en[0] !== 1'b0 || done_valid[0] !== 1'b0 || mem_d[0] !== 8'd0 || done_value[0] !== 8'd0 || init_done !== 1'b0) begin
         errors++; $display("FAIL rstmid_async: got en=%0b dv=%0b d=%0d val=%0d idone=%0b expected all 0",
                            mem_en[0], done_valid[0], mem_d[0], done_value[0], init_done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== 8'd0 || init_done !== 1'b0) begin
         errors++; $display("FAIL rstmid_restart: got en=%0b addr=%0d idone=%0b expected 1,0,0",
                            mem_en[0], mem_addr[0], init_done);
      end
      n = 0;
      while (init_done !== 1'b1 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != 256) begin
         errors++; $display("FAIL rstmid_sweep_len: got %0d cycles expected 256", n);
      end
      idle(3);
      checks++;
      if (mem[9] !== 8'd0) begin
         errors++; $display("FAIL rstmid_cleared: got %0d expected 0", mem[9]);
      end
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_single();
      test_back_to_back();
      test_parallel();
      test_conflict();
      test_cross_forward();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
